systolic_matmul_array: RTL and testbench
========================================

# systolic_matmul_array

Parametrised 2-D output-stationary systolic array: a ROWS×COLS grid of signed integer multiply-accumulate PEs. It computes C = A·B over K streamed beats, with internal input skewing, per-row/per-column masks, and an optional accumulate-onto-previous mode. It is the next generation of the 1-D per-unit multiply array. Operands arrive on a valid/ready stream and results leave one row per handshake, so the block sits directly between the operand buffers and the result writeback path.

## Interface
- DATA_W, 16, operand width (signed two's complement)
- ACC_W, 40, accumulator width per PE
- ROWS, 4, PE rows (≥1)
- COLS, 4, PE columns (≥1)
- K_W, 8, width of beat-count input
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a job; sampled only in IDLE
- k_len  in  K_W  number of beats in the job, latched on start
- accumulate  in  1  latched on start; 0 = clear all accumulators, 1 = add to existing contents
- row_mask  in  ROWS  latched on start; 0 = row disabled
- col_mask  in  COLS  latched on start; 0 = column disabled
- in_valid  in  1  a_in/b_in beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- a_in  in  ROWS×DATA_W  column k of A; element i feeds row i
- b_in  in  COLS×DATA_W  row k of B; element j feeds column j
- out_valid  out  1  out_row holds a result row
- out_ready  in  1  consumer accepts row
- out_row  out  COLS×ACC_W  accumulators of row out_row_idx
- out_row_idx  out  $clog2(ROWS) (min 1)  index of row presented
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last row handshake

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: on start, latch k_len, accumulate, and masks. If accumulate=0, clear every accumulator in that cycle. Go to LOAD if k_len≠0, else go to DRAIN.
- LOAD: in_ready=1. Each accepted beat is one pipeline advance. After the k_len-th accepted beat, go to FLUSH, or to DRAIN if ROWS+COLS-2=0.
- FLUSH: in_ready=0. Zeros are injected. It lasts exactly ROWS+COLS-2 cycles, one advance per cycle, then the FSM goes to DRAIN.
- Pipeline holds completely on cycles with no advance (LOAD with in_valid=0).
- Skew: row i's a-element is delayed i advances and column j's b-element j advances before entering the grid. On each advance a moves right and b moves down one PE. On advance n, PE(i,j) adds the product of beat n-i-j.
- PE: acc ← acc + sext(a)·sext(b). The product is the full 2·DATA_W-bit signed value, sign-extended to ACC_W. The sum wraps modulo 2^ACC_W, with no saturation.
- Masked PE (row_mask[i]=0 or col_mask[j]=0): accumulator does not update, and its out_row field reads 0.
- DRAIN: present rows 0..ROWS-1 in order. out_valid=1 and out_row is stable until out_ready. out_row_idx advances on each handshake. After the ROWS-1 handshake, pulse done and go to IDLE.
- Accumulators retain their values in IDLE, which is what accumulate=1 relies on.
- start outside IDLE is ignored. in_valid outside LOAD is ignored.

## Timing
- Reset (reset=0 at clk edge):
  - FSM → IDLE, and all accumulators and skew registers → 0.
  - in_ready=0, out_valid=0, out_row=0, out_row_idx=0, busy=0, done=0.
  - Reset mid-job aborts the job; no partial output is produced.
- start→busy: busy=1 from the cycle after start.
  - k_len≠0: in_ready=1 from the cycle after start.
  - k_len=0: out_valid=1 from the cycle after start.
- Last beat accept at cycle t → out_valid first high at t+ROWS+COLS-1 (t+1 for 1×1).
- Full-throughput job with no stalls: start to first out_valid = 1+k_len+ROWS+COLS-2 cycles. Drain takes ROWS cycles at out_ready=1.
- done asserts in the cycle after the final row handshake, together with busy=0. A start in that cycle is accepted.

## Test plan
- Identity × B: a_in beat k = e_k (one-hot, value 1), b_in beat k = row k of B with B[i][j]=10·i+j, k_len=4, accumulate=0 → out_row r equals {10r, 10r+1, 10r+2, 10r+3}, then done pulses once.
- Accumulate mode: job 1 with all a=2, b=3, k_len=1, accumulate=0 → every element 6. Job 2 identical but accumulate=1 → every element 12.
- Signed/wrap:
  - a=-3, b=5, k_len=1 → 0xFFFFFFFFF1 (-15) in all PEs.
  - a=b=-32768, k_len=2 → 0x0080000000.
- Masks: row_mask=4'b1011, col_mask=4'b1110, all a=b=1, k_len=3 → row 2 all 0, column 0 all 0, others 3.
- Backpressure: identity test with in_valid toggled 1/0 and out_ready low for 3 cycles per row → identical results, out_row stable while out_valid & !out_ready.
- Reset mid-LOAD after 2 beats, then a new job with k_len=0, accumulate=1 → all outputs 0 and out_valid one cycle after start.

Source files
------------

// File: rtl/systolic_matmul_array_if.sv
// rtl/systolic_matmul_array_if.sv - job control, operand stream and result stream bundle for systolic_matmul_array
interface systolic_matmul_array_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_W    = 8,
  parameter int IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1
);
  logic                        start;
  logic [K_W-1:0]              k_len;
  logic                        accumulate;
  logic [ROWS-1:0]             row_mask;
  logic [COLS-1:0]             col_mask;
  logic                        in_valid;
  logic                        in_ready;
  logic [ROWS-1:0][DATA_W-1:0] a_in;
  logic [COLS-1:0][DATA_W-1:0] b_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [COLS-1:0][ACC_W-1:0]  out_row;
  logic [IDX_W-1:0]            out_row_idx;
  logic                        busy;
  logic                        done;

  modport master (
    output start, k_len, accumulate, row_mask, col_mask, in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, busy, done
  );

  modport slave (
    input  start, k_len, accumulate, row_mask, col_mask, in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, busy, done
  );
endinterface

// File: rtl/systolic_matmul_array.sv
// rtl/systolic_matmul_array.sv - output-stationary ROWSxCOLS signed MAC systolic array
// Operands are skewed on entry so PE(i,j) consumes beat n-i-j on advance n; results drain one row per handshake.
module systolic_matmul_array #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_W    = 8
) (
  input logic                    clk,
  input logic                    reset,
  systolic_matmul_array_if.slave bus
);
  localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FLUSH_LEN = ROWS + COLS - 2;
  localparam int FL_W      = $clog2(ROWS + COLS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [K_W-1:0]  beat_q, beat_d;
  logic [FL_W-1:0] flush_q, flush_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [ROWS-1:0] row_mask_q, row_mask_d;
  logic [COLS-1:0] col_mask_q, col_mask_d;
  logic            done_q, done_d;

  logic in_ready;
  logic out_valid;
  logic adv;
  logic clr_pipe;
  logic clr_acc;
  logic feed_en;
  logic [COLS-1:0][ACC_W-1:0] out_row;

  logic [DATA_W-1:0] a_feed [ROWS];
  logic [DATA_W-1:0] b_feed [COLS];
  logic [DATA_W-1:0] a_op   [ROWS][COLS];
  logic [DATA_W-1:0] b_op   [ROWS][COLS];
  logic [ACC_W-1:0]  acc_w  [ROWS][COLS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      flush_q    <= '0;
      row_q      <= '0;
      row_mask_q <= '0;
      col_mask_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      flush_q    <= flush_d;
      row_q      <= row_d;
      row_mask_q <= row_mask_d;
      col_mask_q <= col_mask_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    flush_d    = flush_q;
    row_d      = row_q;
    row_mask_d = row_mask_q;
    col_mask_d = col_mask_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    adv        = 1'b0;
    clr_pipe   = 1'b0;
    clr_acc    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          beat_d     = bus.k_len;
          row_mask_d = bus.row_mask;
          col_mask_d = bus.col_mask;
          row_d      = '0;
          clr_pipe   = 1'b1;
          clr_acc    = !bus.accumulate;
          state_d    = (bus.k_len != '0) ? S_LOAD : S_DRAIN;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          adv    = 1'b1;
          beat_d = beat_q - 1'b1;
          if (beat_q == K_W'(1)) begin
            flush_d = FL_W'(FLUSH_LEN);
            state_d = (FLUSH_LEN == 0) ? S_DRAIN : S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        adv     = 1'b1;
        flush_d = flush_q - 1'b1;
        if (flush_q == FL_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          row_d = row_q + 1'b1;
          if (row_q == IDX_W'(ROWS - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Masked PEs keep their stale contents, so they are zeroed on the way out.
  always_comb begin
    out_row = '0;
    if (state_q == S_DRAIN) begin
      for (int j = 0; j < COLS; j++) begin
        if (row_mask_q[row_q] && col_mask_q[j]) out_row[j] = acc_w[row_q][j];
      end
    end
  end

  assign feed_en         = (state_q == S_LOAD);
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_row     = out_row;
  assign bus.out_row_idx = row_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;

  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    assign a_feed[i] = feed_en ? bus.a_in[i] : '0;
    if (i == 0) begin : g_direct
      assign a_op[i][0] = a_feed[i];
    end else begin : g_dly
      logic [DATA_W-1:0] sh_q [i];
      always_ff @(posedge clk) begin
        if (!reset || clr_pipe) begin
          for (int k = 0; k < i; k++) sh_q[k] <= '0;
        end else if (adv) begin
          sh_q[0] <= a_feed[i];
          for (int k = 1; k < i; k++) sh_q[k] <= sh_q[k-1];
        end
      end
      assign a_op[i][0] = sh_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bskew
    assign b_feed[j] = feed_en ? bus.b_in[j] : '0;
    if (j == 0) begin : g_direct
      assign b_op[0][j] = b_feed[j];
    end else begin : g_dly
      logic [DATA_W-1:0] sh_q [j];
      always_ff @(posedge clk) begin
        if (!reset || clr_pipe) begin
          for (int k = 0; k < j; k++) sh_q[k] <= '0;
        end else if (adv) begin
          sh_q[0] <= b_feed[j];
          for (int k = 1; k < j; k++) sh_q[k] <= sh_q[k-1];
        end
      end
      assign b_op[0][j] = sh_q[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [2*DATA_W-1:0] a_ext;
      logic signed [2*DATA_W-1:0] b_ext;
      logic signed [2*DATA_W-1:0] prod;
      logic [ACC_W-1:0]           acc_q;

      assign a_ext = (2*DATA_W)'($signed(a_op[i][j]));
      assign b_ext = (2*DATA_W)'($signed(b_op[i][j]));
      assign prod  = a_ext * b_ext;

      always_ff @(posedge clk) begin
        if (!reset || clr_acc) begin
          acc_q <= '0;
        end else if (adv && row_mask_q[i] && col_mask_q[j]) begin
          acc_q <= acc_q + ACC_W'(prod);
        end
      end
      assign acc_w[i][j] = acc_q;

      if (j < COLS - 1) begin : g_apass
        logic [DATA_W-1:0] a_pass_q;
        always_ff @(posedge clk) begin
          if (!reset || clr_pipe) a_pass_q <= '0;
          else if (adv)           a_pass_q <= a_op[i][j];
        end
        assign a_op[i][j+1] = a_pass_q;
      end

      if (i < ROWS - 1) begin : g_bpass
        logic [DATA_W-1:0] b_pass_q;
        always_ff @(posedge clk) begin
          if (!reset || clr_pipe) b_pass_q <= '0;
          else if (adv)           b_pass_q <= b_op[i][j];
        end
        assign b_op[i+1][j] = b_pass_q;
      end
    end
  end
endmodule

// File: tb/tb_systolic_matmul_array.sv
// tb/tb_systolic_matmul_array.sv - scoreboard bench for systolic_matmul_array
// Expected rows come from a plain matrix-product model; a negedge monitor compares every handshake.
module tb_systolic_matmul_array;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int K_W    = 8;
  localparam int IDX_W  = 2;
  localparam int K_MAX  = 16;
  localparam int RW     = COLS * ACC_W;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [RW-1:0]    row;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  systolic_matmul_array_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS), .K_W(K_W)) bus ();

  systolic_matmul_array #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  int jobs = 0;
  int first_valid_cyc = -1;
  int start_cyc = 0;
  int rdy_mode = 0;
  logic prev_valid = 1'b0;
  logic hold = 1'b0;
  logic [RW-1:0] hold_row = '0;
  exp_t exp_q[$];
  logic [ACC_W-1:0] acc_m [ROWS][COLS];
  logic signed [DATA_W-1:0] a_mat [K_MAX][ROWS];
  logic signed [DATA_W-1:0] b_mat [K_MAX][COLS];

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (cyc % 4 == 3);
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (bus.out_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hold && bus.out_valid) chk("row_stable", bus.out_row, hold_row);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_row: idx %0d presented with empty scoreboard", bus.out_row_idx);
        end else begin
          e = exp_q.pop_front();
          chk("row_idx", RW'(bus.out_row_idx), RW'(e.idx));
          chk("row_data", bus.out_row, e.row);
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_busy_low", RW'(bus.busy), '0);
      end
      hold       = bus.out_valid && !bus.out_ready;
      hold_row   = bus.out_row;
      prev_valid = bus.out_valid;
    end else begin
      hold       = 1'b0;
      prev_valid = 1'b0;
    end
  end

  task automatic model_job(input int k, input bit accum, input logic [ROWS-1:0] rm, input logic [COLS-1:0] cm);
    exp_t e;
    longint p;
    if (!accum) begin
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) acc_m[i][j] = '0;
    end
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          if (rm[i] && cm[j]) begin
            p = longint'(a_mat[kk][i]) * longint'(b_mat[kk][j]);
            acc_m[i][j] = acc_m[i][j] + ACC_W'(p);
          end
    for (int r = 0; r < ROWS; r++) begin
      e.idx = IDX_W'(r);
      e.row = '0;
      for (int j = 0; j < COLS; j++) if (rm[r] && cm[j]) e.row[j*ACC_W +: ACC_W] = acc_m[r][j];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.k_len = '0;
    bus.accumulate = 1'b0;
    bus.row_mask = '0;
    bus.col_mask = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_in_ready", RW'(bus.in_ready), '0);
    chk("rst_out_valid", RW'(bus.out_valid), '0);
    chk("rst_out_row", bus.out_row, '0);
    chk("rst_out_row_idx", RW'(bus.out_row_idx), '0);
    chk("rst_busy", RW'(bus.busy), '0);
    chk("rst_done", RW'(bus.done), '0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) acc_m[i][j] = '0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      tick();
      t++;
    end while (bus.busy !== 1'b0 && t < 2000);
    chk("idle_reached", RW'(bus.busy), '0);
  endtask

  task automatic send_beat(input int kk, input bit toggle);
    bit got = 1'b0;
    if (toggle) begin
      bus.in_valid = 1'b0;
      for (int i = 0; i < ROWS; i++) bus.a_in[i] = DATA_W'($urandom);
      for (int j = 0; j < COLS; j++) bus.b_in[j] = DATA_W'($urandom);
      tick();
    end
    bus.in_valid = 1'b1;
    for (int i = 0; i < ROWS; i++) bus.a_in[i] = a_mat[kk][i];
    for (int j = 0; j < COLS; j++) bus.b_in[j] = b_mat[kk][j];
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = bus.in_ready;
      tick();
    end
    chk("beat_accepted", RW'(got), RW'(1));
  endtask

  task automatic run_job(input int k, input bit accum, input logic [ROWS-1:0] rm, input logic [COLS-1:0] cm,
                         input bit toggle, input bit check_lat);
    int t = 0;
    wait_idle();
    bus.start = 1'b1;
    bus.k_len = K_W'(k);
    bus.accumulate = accum;
    bus.row_mask = rm;
    bus.col_mask = cm;
    start_cyc = cyc;
    first_valid_cyc = -1;
    model_job(k, accum, rm, cm);
    tick();
    // Job parameters must have been latched; scramble them to prove it.
    bus.start = 1'b0;
    bus.k_len = K_W'($urandom);
    bus.accumulate = 1'($urandom);
    bus.row_mask = ROWS'($urandom);
    bus.col_mask = COLS'($urandom);
    for (int kk = 0; kk < k; kk++) send_beat(kk, toggle);
    bus.in_valid = 1'b0;
    while (done_cnt < jobs + 1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    jobs++;
    chk("done_count", RW'(done_cnt), RW'(jobs));
    if (check_lat)
      chk("first_valid_latency", RW'(first_valid_cyc - start_cyc), RW'((k == 0) ? 1 : k + ROWS + COLS - 1));
  endtask

  task automatic fill_const(input int a, input int b, input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < ROWS; i++) a_mat[kk][i] = DATA_W'(a);
      for (int j = 0; j < COLS; j++) b_mat[kk][j] = DATA_W'(b);
    end
  endtask

  task automatic fill_identity();
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < ROWS; i++) a_mat[kk][i] = (i == kk) ? 16'sd1 : 16'sd0;
      for (int j = 0; j < COLS; j++) b_mat[kk][j] = DATA_W'(10 * kk + j);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    bit tg;
    do_reset();

    fill_identity();
    run_job(4, 1'b0, '1, '1, 1'b0, 1'b1);

    fill_const(2, 3, 1);
    run_job(1, 1'b0, '1, '1, 1'b0, 1'b1);
    run_job(1, 1'b1, '1, '1, 1'b0, 1'b1);

    fill_const(-3, 5, 1);
    run_job(1, 1'b0, '1, '1, 1'b0, 1'b1);
    fill_const(-32768, -32768, 2);
    run_job(2, 1'b0, '1, '1, 1'b0, 1'b1);

    fill_const(1, 1, 3);
    run_job(3, 1'b0, 4'b1011, 4'b1110, 1'b0, 1'b1);

    fill_identity();
    rdy_mode = 1;
    run_job(4, 1'b0, '1, '1, 1'b1, 1'b0);

    rdy_mode = 2;
    for (int n = 0; n < 8; n++) begin
      k = $urandom_range(1, K_MAX);
      tg = 1'($urandom_range(0, 1));
      for (int kk = 0; kk < K_MAX; kk++) begin
        for (int i = 0; i < ROWS; i++) a_mat[kk][i] = DATA_W'($urandom);
        for (int j = 0; j < COLS; j++) b_mat[kk][j] = DATA_W'($urandom);
      end
      run_job(k, 1'($urandom_range(0, 1)), ROWS'($urandom), COLS'($urandom), tg, !tg);
    end
    rdy_mode = 0;

    // Abort a job mid-LOAD; the follow-up job must see cleared accumulators.
    fill_const(7, 9, 4);
    wait_idle();
    bus.start = 1'b1;
    bus.k_len = K_W'(4);
    bus.accumulate = 1'b1;
    bus.row_mask = '1;
    bus.col_mask = '1;
    tick();
    bus.start = 1'b0;
    send_beat(0, 1'b0);
    send_beat(1, 1'b0);
    do_reset();
    run_job(0, 1'b1, '1, '1, 1'b0, 1'b1);

    repeat (5) tick();
    chk("scoreboard_empty", RW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
